// File: rtl/alu_ctrl_if.sv
// Handshake/bus bundle between the ALU control sequencer and the surrounding core
// (imem, register file, ALU flags, dmem).
interface alu_ctrl_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 9
);
    logic               start;
    logic [INSTR_W-1:0] instr_in;
    logic               imem_ack;
    logic               alu_jump;
    logic [PC_W-1:0]    br_target;
    logic               dmem_ack;

    logic [PC_W-1:0]    pc_out;
    logic               imem_req;
    logic [2:0]         alu_op;
    logic [2:0]         ra_sel;
    logic [2:0]         rb_sel;
    logic               reg_we;
    logic               car_we;
    logic               dmem_re;
    logic               dmem_we;
    logic               busy;
    logic               done;
    logic [15:0]        cycle_count;

    modport master (
        input  start, instr_in, imem_ack, alu_jump, br_target, dmem_ack,
        output pc_out, imem_req, alu_op, ra_sel, rb_sel, reg_we, car_we,
               dmem_re, dmem_we, busy, done, cycle_count
    );

    modport slave (
        output start, instr_in, imem_ack, alu_jump, br_target, dmem_ack,
        input  pc_out, imem_req, alu_op, ra_sel, rb_sel, reg_we, car_we,
               dmem_re, dmem_we, busy, done, cycle_count
    );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the 8-bit ALU core.
// Optional busy-cycle counter enabled by defining ALU_CTRL_CYCLE_COUNT_EN.
module alu_ctrl_fsm #(
    parameter int unsigned        PC_W      = 8,
    parameter int unsigned        INSTR_W   = 9,
    parameter logic [INSTR_W-1:0] HALT_WORD = 9'h1FF
) (
    input  logic       clk,
    input  logic       reset,
    alu_ctrl_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SRL = 3'd3;
    localparam logic [2:0] OP_SRA = 3'd4;
    localparam logic [2:0] OP_BEQ = 3'd5;
    localparam logic [2:0] OP_LW  = 3'd6;
    localparam logic [2:0] OP_MEM = 3'd6;

    logic [2:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [2:0]         r_alu_op;
    logic [2:0]         r_ra_sel;
    logic [2:0]         r_rb_sel;
    logic               r_imem_req;
    logic               r_reg_we;
    logic               r_car_we;
    logic               r_dmem_re;
    logic               r_dmem_we;
    logic               r_busy;
    logic               r_done;

    logic [2:0]         w_state_nxt;
    logic [PC_W-1:0]    w_pc_nxt;
    logic               w_load_ir;
    logic [2:0]         w_opc;
    logic [2:0]         w_in_opc;
    logic               w_state_busy;

    assign w_opc        = r_ir[INSTR_W-1 -: 3];
    assign w_in_opc     = bus.instr_in[INSTR_W-1 -: 3];
    assign w_state_busy = (r_state != S_IDLE) && (r_state != S_HALTED);

    // Next-state and next-PC decode
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load_ir   = 1'b0;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    w_load_ir   = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: w_state_nxt = (r_ir == HALT_WORD) ? S_HALTED : S_EXEC;
            S_EXEC: begin
                if (w_opc == OP_BEQ) begin
                    w_pc_nxt    = bus.alu_jump ? bus.br_target : r_pc + PC_W'(1);
                    w_state_nxt = S_FETCH;
                end else if (w_opc >= OP_MEM) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    if (w_opc == OP_LW) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_pc_nxt    = r_pc + PC_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_pc_nxt    = r_pc + PC_W'(1);
                w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, PC/IR and registered Moore outputs decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_alu_op   <= 3'd0;
            r_ra_sel   <= 3'd0;
            r_rb_sel   <= 3'd0;
            r_imem_req <= 1'b0;
            r_reg_we   <= 1'b0;
            r_car_we   <= 1'b0;
            r_dmem_re  <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_load_ir) begin
                r_ir     <= bus.instr_in;
                r_alu_op <= (w_in_opc < OP_MEM) ? w_in_opc : OP_MEM;
                r_ra_sel <= bus.instr_in[5:3];
                r_rb_sel <= bus.instr_in[2:0];
            end
            r_imem_req <= (w_state_nxt == S_FETCH);
            r_dmem_re  <= (w_state_nxt == S_MEM) && (w_opc == OP_LW);
            r_dmem_we  <= (w_state_nxt == S_MEM) && (w_opc != OP_LW);
            r_reg_we   <= (w_state_nxt == S_WB);
            r_car_we   <= (w_state_nxt == S_WB) &&
                          ((w_opc == OP_ADD) || (w_opc == OP_SRL) || (w_opc == OP_SRA));
            r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALTED);
            r_done     <= (w_state_nxt == S_HALTED);
        end
    end

    assign bus.pc_out   = r_pc;
    assign bus.imem_req = r_imem_req;
    assign bus.alu_op   = r_alu_op;
    assign bus.ra_sel   = r_ra_sel;
    assign bus.rb_sel   = r_rb_sel;
    assign bus.reg_we   = r_reg_we;
    assign bus.car_we   = r_car_we;
    assign bus.dmem_re  = r_dmem_re;
    assign bus.dmem_we  = r_dmem_we;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

`ifdef ALU_CTRL_CYCLE_COUNT_EN
    logic [15:0] r_cycle_cnt;

    // The cycle that accepts start is counted as the first cycle of the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= 16'd0;
        end else if (!w_state_busy && bus.start) begin
            r_cycle_cnt <= 16'd1;
        end else if (w_state_busy && (r_cycle_cnt != 16'hFFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign bus.cycle_count = r_cycle_cnt;
`else
    assign bus.cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed self-checking bench for alu_ctrl_fsm: reset, ALU/BEQ/LW/SW sequencing,
// PC wrap, halt/restart and the optional cycle counter.
module tb_alu_ctrl_fsm;
    localparam logic [8:0] HALT  = 9'h1FF;
    localparam logic [8:0] I_ADD = 9'b010_001_010;
    localparam logic [8:0] I_BEQ = 9'b101_000_001;
    localparam logic [8:0] I_LW  = 9'b110_011_100;
    localparam logic [8:0] I_SW  = 9'b111_000_000;
    localparam logic [8:0] I_OR  = 9'b001_001_001;

    logic clk = 1'b0;
    logic reset;
    logic imem_auto;
    logic dmem_auto;
    logic dmem_force;
    logic [8:0] imem [256];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_ctrl_if bus ();

    alu_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Zero-wait memory responders, with a manual override for delayed dmem acks
    assign bus.instr_in = imem[bus.pc_out];
    assign bus.imem_ack = imem_auto & bus.imem_req;
    assign bus.dmem_ack = dmem_force | (dmem_auto & (bus.dmem_re | bus.dmem_we));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {8'd0, bus.pc_out, bus.imem_req, bus.alu_op, bus.ra_sel, bus.rb_sel,
                bus.reg_we, bus.car_we, bus.dmem_re, bus.dmem_we, bus.busy, bus.done};
    endfunction

    initial begin
        int k;
        logic [15:0] exp_cnt;
        for (int i = 0; i < 256; i++) imem[i] = HALT;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.alu_jump  = 1'b0;
        bus.br_target = 8'h00;
        imem_auto     = 1'b1;
        dmem_auto     = 1'b0;
        dmem_force    = 1'b0;
        step();
        step();
        chk("reset_outs", all_outs(), 32'd0);
        chk("reset_cnt", 32'(bus.cycle_count), 32'd0);
        reset = 1'b0;
        step();

        // Reset while a store is waiting in MEM
        imem[0] = I_SW;
        start_pulse();
        step(); step(); step();
        chk("sw_mem_we", {31'd0, bus.dmem_we}, 32'd1);
        chk("sw_mem_re", {31'd0, bus.dmem_re}, 32'd0);
        reset = 1'b1;
        #1;
        chk("async_reset_outs", all_outs(), 32'd0);
        step();
        chk("reset_next_cycle_outs", all_outs(), 32'd0);
        reset = 1'b0;
        step();
        dmem_force = 1'b1;
        step();
        dmem_force = 1'b0;
        step();
        chk("late_ack_outs", all_outs(), 32'd0);

        // ADD r1,r2 with zero-wait fetch
        dmem_auto = 1'b1;
        imem[0]   = I_ADD;
        start_pulse();
        chk("add_fetch", {bus.pc_out, bus.imem_req, bus.busy}, {8'h00, 1'b1, 1'b1});
        step();
        chk("add_decode_sel", {bus.alu_op, bus.ra_sel, bus.rb_sel, bus.reg_we},
            {3'd2, 3'd1, 3'd2, 1'b0});
        step();
        chk("add_exec_we", {bus.reg_we, bus.car_we}, 2'b00);
        step();
        chk("add_wb_we", {bus.reg_we, bus.car_we}, 2'b11);
        step();
        chk("add_after_wb", {bus.pc_out, bus.reg_we, bus.car_we, bus.imem_req},
            {8'h01, 1'b0, 1'b0, 1'b1});
        step(); step();
        chk("add_halt", {bus.done, bus.busy}, 2'b10);

        // BEQ taken, then not taken
        imem[0]       = I_BEQ;
        bus.alu_jump  = 1'b1;
        bus.br_target = 8'h40;
        start_pulse();
        chk("restart_done_clr", {bus.pc_out, bus.done, bus.busy}, {8'h00, 1'b0, 1'b1});
        step();
        chk("beq_decode_op", {bus.alu_op, bus.reg_we}, {3'd5, 1'b0});
        step();
        chk("beq_exec_we", {bus.reg_we, bus.car_we}, 2'b00);
        step();
        chk("beq_taken_pc", {bus.pc_out, bus.imem_req, bus.reg_we}, {8'h40, 1'b1, 1'b0});
        step(); step();
        chk("beq_taken_halt", {31'd0, bus.done}, 32'd1);
        bus.alu_jump = 1'b0;
        start_pulse();
        step(); step(); step();
        chk("beq_not_taken_pc", {bus.pc_out, bus.imem_req, bus.reg_we}, {8'h01, 1'b1, 1'b0});
        step(); step();
        chk("beq_nt_halt", {31'd0, bus.done}, 32'd1);

        // LW with dmem ack arriving in the fourth MEM cycle
        dmem_auto = 1'b0;
        imem[0]   = I_LW;
        start_pulse();
        step();
        chk("lw_decode_sel", {bus.alu_op, bus.ra_sel, bus.rb_sel}, {3'd6, 3'd3, 3'd4});
        step(); step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lw_mem_re_%0d", i), {bus.dmem_re, bus.dmem_we, bus.reg_we}, 3'b100);
            if (i == 3) dmem_force = 1'b1;
            step();
        end
        dmem_force = 1'b0;
        chk("lw_wb", {bus.reg_we, bus.car_we, bus.dmem_re}, 3'b100);
        step();
        chk("lw_next_fetch", {bus.pc_out, bus.reg_we}, {8'h01, 1'b0});
        step(); step();
        dmem_auto = 1'b1;

        // OR at PC 0xFF: PC wraps to 0
        imem[0]       = I_BEQ;
        imem[8'hFF]   = I_OR;
        bus.alu_jump  = 1'b1;
        bus.br_target = 8'hFF;
        start_pulse();
        step(); step(); step();
        chk("wrap_fetch_ff", {24'd0, bus.pc_out}, 32'hFF);
        step();
        chk("or_decode_op", {29'd0, bus.alu_op}, 32'd1);
        step(); step();
        chk("or_wb_no_carry", {bus.reg_we, bus.car_we}, 2'b10);
        step();
        chk("wrap_pc_00", {bus.pc_out, bus.imem_req}, {8'h00, 1'b1});
        reset = 1'b1;
        step();
        reset        = 1'b0;
        bus.alu_jump = 1'b0;
        step();

        // ADD, SW, HALT program and restart
        imem[0] = I_ADD;
        imem[1] = I_SW;
        imem[2] = HALT;
        start_pulse();
        k = 0;
        while (!bus.done && k < 40) begin
            step();
            k++;
        end
        chk("prog_latency", 32'(k), 32'd10);
        chk("prog_halted", {bus.pc_out, bus.done, bus.busy}, {8'h02, 1'b1, 1'b0});
`ifdef ALU_CTRL_CYCLE_COUNT_EN
        exp_cnt = 16'd11;
`else
        exp_cnt = 16'd0;
`endif
        chk("prog_cycle_count", 32'(bus.cycle_count), 32'(exp_cnt));
        step();
        chk("halted_cnt_frozen", {bus.cycle_count, 7'd0, bus.pc_out, bus.done},
            {exp_cnt, 7'd0, 8'h02, 1'b1});
        start_pulse();
        chk("prog_restart", {bus.pc_out, bus.done, bus.busy}, {8'h00, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle control sequencer that drives the 8-bit ALU: fetches 9-bit instructions, decodes them, and issues ALU op codes and register selects.
- Consumes the ALU branch flag, sequences data-memory handshakes and register write-back, and maintains the 8-bit PC.
- Sits between instruction memory, register file, ALU and data memory in the emulator core.

Parameters:
- PC_W, 8, program counter width (PC wraps modulo 2^PC_W)
- INSTR_W, 9, instruction width
- HALT_WORD, 9'h1FF, reserved encoding that stops execution

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin execution at PC 0; ignored while busy
- instr_in  in  9  instruction word from imem, valid when imem_ack=1
- imem_ack  in  1  imem data-valid strobe
- alu_jump  in  1  ALU branch result for BEQ
- br_target  in  8  branch target supplied by datapath
- dmem_ack  in  1  data-memory completion strobe
- pc_out  out  8  current PC / imem address
- imem_req  out  1  instruction fetch request
- alu_op  out  3  ALU op: 0 AND, 1 OR, 2 ADD, 3 SRL, 4 SRA, 5 BEQ, 6 LW/SW
- ra_sel  out  3  register A index (IR[5:3])
- rb_sel  out  3  register B index (IR[2:0])
- reg_we  out  1  write ALU/mem result to ra_sel
- car_we  out  1  write ALU carry output to carry register
- dmem_re  out  1  data-memory read request
- dmem_we  out  1  data-memory write request
- busy  out  1  high from start until halt
- done  out  1  high in HALTED
- cycle_count  out  16  cycles since start (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE, PC=0, IR=0. All outputs 0. A pending imem or dmem request is dropped; late acks are ignored.
- IR format: [8:6] opcode, [5:3] ra, [2:0] rb.
  - Opcodes 0-5 map to alu_op directly.
  - 6 = LW, 7 = SW; both drive alu_op=6.
  - HALT_WORD overrides opcode 7.
- ra_sel, rb_sel and alu_op are registered from IR and held stable DECODE through WB.
- IDLE: busy=0. start=1 -> PC=0, FETCH.
- FETCH: imem_req=1, pc_out=PC; wait any number of cycles. imem_ack=1 -> IR<=instr_in, DECODE. Ack in the first FETCH cycle is legal.
- DECODE: 1 cycle. IR==HALT_WORD -> HALTED; else -> EXEC.
- EXEC: 1 cycle, alu_op valid.
  - Ops 0-4 -> WB.
  - BEQ: PC<=br_target if alu_jump=1, else PC+1; then FETCH. No write-back.
  - LW/SW -> MEM.
- MEM: dmem_re (LW) or dmem_we (SW) held high until dmem_ack.
  - LW -> WB.
  - SW -> PC+1, FETCH.
  - dmem_re and dmem_we are never both high.
- WB: 1 cycle. reg_we=1; car_we=1 only for ADD/SRL/SRA. PC<=PC+1, then FETCH.
- HALTED: done=1, busy=0, PC frozen. start=1 -> PC=0, FETCH, done clears the next cycle.
- busy=1 in every state except IDLE and HALTED.
- PC increment wraps 255 -> 0 with no flag.
- Latency with zero-wait acks:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - BEQ: 3 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
- Simultaneous events:
  - start while busy: ignored.
  - reset with any ack: reset wins.
  - Ack outside the matching wait state: ignored.

Optional Feature:
- Macro: ALU_CTRL_CYCLE_COUNT_EN.
- Defined:
  - 16-bit counter clears on accepted start, increments every cycle while busy, and freezes in HALTED.
  - Saturates at 16'hFFFF.
  - Reset clears it.
- Undefined: cycle_count is tied to 0 and no counter logic exists.

Test Plan:
- Reset mid-MEM (dmem_we=1) -> next cycle all outputs 0, state IDLE; a following dmem_ack causes no PC change.
- start; imem returns 9'b010_001_010 (ADD r1,r2) with 0-wait ack -> alu_op=2, ra_sel=1, rb_sel=2; reg_we=car_we=1 for exactly one cycle in cycle 4; PC=1.
- BEQ (9'b101_000_001): alu_jump=1 with br_target=8'h40 -> next fetch pc_out=8'h40; alu_jump=0 -> pc_out=PC+1; reg_we never asserted.
- LW with dmem_ack delayed 3 cycles -> dmem_re high 4 cycles, then reg_we=1 for one cycle, car_we=0.
- PC=8'hFF executing OR -> next fetch pc_out=8'h00.
- Program ADD, SW, HALT_WORD with 0-wait memories -> done=1, busy=0; with macro defined cycle_count=11; start re-asserted -> pc_out=0, done=0 the next cycle.
